// File: rtl/ctrl_exec_mem_slice.sv
// ctrl_exec_mem_slice
//   MIPS-subset execute slice: opcode decode into control, ALU, zero flag,
//   branch target and next-PC selection, plus a word-addressed data memory.
//   Every result is registered once for the write-back stage (latency 1).
//
// Ports
//   clk             in   1   single clock, all state updates on posedge
//   reset           in   1   synchronous active-high; clears outputs and memory
//   opcode          in   6   instr[31:26]
//   rs_data         in   32  ALU operand A
//   rt_data         in   32  ALU operand B (R-type / beq), store data
//   sign_ext        in   32  sign-extended immediate; funct = sign_ext[5:0]
//   rt_addr         in   5   instr[20:16]
//   rd_addr         in   5   instr[15:11]
//   pc              in   32  PC+4 of this instruction
//   reg_write_out   out  1   write-back enable
//   mem_to_reg_out  out  1   write-back select, 1 = read_data_out
//   wr_reg_out      out  5   destination register
//   result_out      out  32  ALU result
//   read_data_out   out  32  load data (0 when not a load)
//   zero_out        out  1   ALU result == 0
//   branch_taken    out  1   beq and zero
//   branch_addr_out out  32  pc + (sign_ext << 2)
//   pc_out          out  32  branch_taken ? branch_addr_out : pc
module ctrl_exec_mem_slice #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] sign_ext,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] pc,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic [4:0]  wr_reg_out,
    output logic [31:0] result_out,
    output logic [31:0] read_data_out,
    output logic        zero_out,
    output logic        branch_taken,
    output logic [31:0] branch_addr_out,
    output logic [31:0] pc_out
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // Unlisted opcodes fall through as all-zero control: a harmless NOP.
    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALU_SUB;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] alu_exec(input logic [1:0]         alu_op,
                                             input logic [5:0]         funct,
                                             input logic signed [31:0] a,
                                             input logic signed [31:0] b);
        logic [31:0] r;
        r = '0;
        case (alu_op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_FUNCT: begin
                case (funct)
                    FN_ADD:  r = a + b;
                    FN_SUB:  r = a - b;
                    FN_AND:  r = a & b;
                    FN_OR:   r = a | b;
                    FN_SLT:  r = (a < b) ? 32'd1 : 32'd0;
                    default: r = '0;
                endcase
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    ctrl_t                 w_ctrl;
    logic [31:0]           w_alu_b;
    logic [31:0]           w_result;
    logic [31:0]           w_branch_addr;
    logic [31:0]           w_read_data;
    logic [ADDR_BITS-1:0]  w_mem_idx;
    logic                  w_zero;
    logic                  w_taken;
    logic [31:0]           r_mem [MEM_DEPTH];

    // Decode / execute (combinational)
    assign w_ctrl        = decode(opcode);
    assign w_alu_b       = w_ctrl.alu_src ? sign_ext : rt_data;
    assign w_result      = alu_exec(w_ctrl.alu_op, sign_ext[5:0], rs_data, w_alu_b);
    assign w_zero        = (w_result == 32'd0);
    assign w_taken       = w_ctrl.branch & w_zero;
    assign w_branch_addr = pc + {sign_ext[29:0], 2'b00};

    // Byte offset bits and everything above the index are dropped, so
    // addresses wrap around the memory.
    assign w_mem_idx     = w_result[ADDR_BITS+1:2];
    assign w_read_data   = w_ctrl.mem_read ? r_mem[w_mem_idx] : 32'd0;

    // Memory stage: write at the edge; reset wins over a pending store
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_ctrl.mem_write) begin
            r_mem[w_mem_idx] <= rt_data;
        end
    end

    // Write-back register boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_out   <= 1'b0;
            mem_to_reg_out  <= 1'b0;
            wr_reg_out      <= '0;
            result_out      <= '0;
            read_data_out   <= '0;
            zero_out        <= 1'b0;
            branch_taken    <= 1'b0;
            branch_addr_out <= '0;
            pc_out          <= '0;
        end else begin
            reg_write_out   <= w_ctrl.reg_write;
            mem_to_reg_out  <= w_ctrl.mem_to_reg;
            wr_reg_out      <= w_ctrl.reg_dst ? rd_addr : rt_addr;
            result_out      <= w_result;
            read_data_out   <= w_read_data;
            zero_out        <= w_zero;
            branch_taken    <= w_taken;
            branch_addr_out <= w_branch_addr;
            pc_out          <= w_taken ? w_branch_addr : pc;
        end
    end

endmodule

// File: tb/tb_ctrl_exec_mem_slice.sv
// Testbench for ctrl_exec_mem_slice: vector table, hand sequences for
// memory/reset corner cases, and randomized traffic against a reference model.
module tb_ctrl_exec_mem_slice;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [31:0] rs_data, rt_data, sign_ext, pc;
    logic [4:0]  rt_addr, rd_addr;
    logic        reg_write_out, mem_to_reg_out, zero_out, branch_taken;
    logic [4:0]  wr_reg_out;
    logic [31:0] result_out, read_data_out, branch_addr_out, pc_out;

    always #5 clk = ~clk;

    ctrl_exec_mem_slice #(.MEM_DEPTH(256), .ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .rs_data(rs_data),
        .rt_data(rt_data), .sign_ext(sign_ext), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .pc(pc), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .wr_reg_out(wr_reg_out),
        .result_out(result_out), .read_data_out(read_data_out),
        .zero_out(zero_out), .branch_taken(branch_taken),
        .branch_addr_out(branch_addr_out), .pc_out(pc_out)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: memory contents and expected registered outputs
    logic [31:0] mmem [256];
    logic        e_rw, e_m2r, e_z, e_bt;
    logic [4:0]  e_wr;
    logic [31:0] e_res, e_rd, e_ba, e_pc;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a, b, imm;
        logic [4:0]  rta, rda;
        logic [31:0] p;
        logic [31:0] res;
        logic        rw;
        logic [4:0]  wr;
        logic        z, bt;
        logic [31:0] ba, npc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Applies one instruction (or a reset cycle) and advances the model.
    task automatic drive(input logic rst, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rta,
                         input logic [4:0] rda, input logic [31:0] p);
        logic [31:0] res;
        logic        is_br;
        int          widx;
        reset = rst; opcode = op; rs_data = a; rt_data = b;
        sign_ext = imm; rt_addr = rta; rd_addr = rda; pc = p;
        res = 0; is_br = 0;
        e_rw = 0; e_m2r = 0; e_wr = rta; e_rd = 0;
        if (rst) begin
            for (int i = 0; i < 256; i++) mmem[i] = 0;
            e_wr = 0; e_res = 0; e_z = 0; e_bt = 0; e_ba = 0; e_pc = 0;
        end else begin
            case (op)
                6'h00: begin
                    e_rw = 1; e_wr = rda;
                    case (imm[5:0])
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
                        default: res = 0;
                    endcase
                end
                6'h23: begin
                    e_rw = 1; e_m2r = 1;
                    res = a + imm;
                    widx = int'((res / 4) % 256);
                    e_rd = mmem[widx];
                end
                6'h2B: begin
                    res = a + imm;
                    widx = int'((res / 4) % 256);
                    mmem[widx] = b;
                end
                6'h04: begin
                    res = a - b; is_br = 1;
                end
                default: res = a + b;
            endcase
            e_res = res;
            e_z   = (res == 0);
            e_bt  = is_br && e_z;
            e_ba  = p + imm * 4;
            e_pc  = e_bt ? e_ba : p;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".reg_write"},  {31'd0, reg_write_out},  {31'd0, e_rw});
        chk({tag, ".mem_to_reg"}, {31'd0, mem_to_reg_out}, {31'd0, e_m2r});
        chk({tag, ".wr_reg"},     {27'd0, wr_reg_out},     {27'd0, e_wr});
        chk({tag, ".result"},     result_out,              e_res);
        chk({tag, ".read_data"},  read_data_out,           e_rd);
        chk({tag, ".zero"},       {31'd0, zero_out},       {31'd0, e_z});
        chk({tag, ".taken"},      {31'd0, branch_taken},   {31'd0, e_bt});
        chk({tag, ".br_addr"},    branch_addr_out,         e_ba);
        chk({tag, ".pc_out"},     pc_out,                  e_pc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".reg_write"},  {31'd0, reg_write_out},  0);
        chk({tag, ".mem_to_reg"}, {31'd0, mem_to_reg_out}, 0);
        chk({tag, ".wr_reg"},     {27'd0, wr_reg_out},     0);
        chk({tag, ".result"},     result_out,              0);
        chk({tag, ".read_data"},  read_data_out,           0);
        chk({tag, ".zero"},       {31'd0, zero_out},       0);
        chk({tag, ".taken"},      {31'd0, branch_taken},   0);
        chk({tag, ".br_addr"},    branch_addr_out,         0);
        chk({tag, ".pc_out"},     pc_out,                  0);
    endtask

    initial begin
        logic [5:0]  rop;
        logic [31:0] ra, rb, rimm;
        logic [5:0]  fn;
        int          sel;

        tbl[0]  = '{"r_add",    6'h00, 32'd5,        32'd7,        32'h20, 5'd1, 5'd9,  32'h0,   32'd12,       1'b1, 5'd9,  1'b0, 1'b0, 32'h80,  32'h0};
        tbl[1]  = '{"slt_neg",  6'h00, 32'hFFFFFFFD, 32'd2,        32'h2A, 5'd1, 5'd10, 32'h0,   32'd1,        1'b1, 5'd10, 1'b0, 1'b0, 32'hA8,  32'h0};
        tbl[2]  = '{"slt_swap", 6'h00, 32'd2,        32'hFFFFFFFD, 32'h2A, 5'd1, 5'd11, 32'h0,   32'd0,        1'b1, 5'd11, 1'b1, 1'b0, 32'hA8,  32'h0};
        tbl[3]  = '{"r_sub",    6'h00, 32'd5,        32'd7,        32'h22, 5'd1, 5'd12, 32'h0,   32'hFFFFFFFE, 1'b1, 5'd12, 1'b0, 1'b0, 32'h88,  32'h0};
        tbl[4]  = '{"r_and",    6'h00, 32'hF0F0,     32'hFF00,     32'h24, 5'd1, 5'd13, 32'h0,   32'hF000,     1'b1, 5'd13, 1'b0, 1'b0, 32'h90,  32'h0};
        tbl[5]  = '{"r_or",     6'h00, 32'hF0F0,     32'hFF00,     32'h25, 5'd1, 5'd14, 32'h0,   32'hFFF0,     1'b1, 5'd14, 1'b0, 1'b0, 32'h94,  32'h0};
        tbl[6]  = '{"r_badfn",  6'h00, 32'd5,        32'd7,        32'h21, 5'd1, 5'd15, 32'h0,   32'd0,        1'b1, 5'd15, 1'b1, 1'b0, 32'h84,  32'h0};
        tbl[7]  = '{"beq_take", 6'h04, 32'd3,        32'd3,        32'd4,  5'd6, 5'd7,  32'h100, 32'd0,        1'b0, 5'd6,  1'b1, 1'b1, 32'h110, 32'h110};
        tbl[8]  = '{"beq_not",  6'h04, 32'd3,        32'd4,        32'd4,  5'd6, 5'd7,  32'h100, 32'hFFFFFFFF, 1'b0, 5'd6,  1'b0, 1'b0, 32'h110, 32'h100};
        tbl[9]  = '{"beq_back", 6'h04, 32'd5,        32'd5,        32'hFFFFFFFC, 5'd6, 5'd7, 32'h100, 32'd0,   1'b0, 5'd6,  1'b1, 1'b1, 32'hF0,  32'hF0};
        tbl[10] = '{"undef",    6'h3F, 32'd1,        32'd2,        32'h20, 5'd8, 5'd9,  32'h40,  32'd3,        1'b0, 5'd8,  1'b0, 1'b0, 32'hC0,  32'h40};
        tbl[11] = '{"add_wrap", 6'h00, 32'hFFFFFFFF, 32'd1,        32'h20, 5'd1, 5'd16, 32'h0,   32'd0,        1'b1, 5'd16, 1'b1, 1'b0, 32'h80,  32'h0};

        // Reset held two cycles with a store presented
        drive(1, 6'h2B, 32'h0, 32'h11111111, 32'h0, 5'd1, 5'd2, 32'h20);
        tick(); check_zero("rst1");
        tick(); check_zero("rst2");
        drive(0, 6'h23, 32'h0, 32'h0, 32'h0, 5'd2, 5'd0, 32'h0);
        tick();
        chk("rst_mem0", read_data_out, 32'h0);
        chk("rst_lw_m2r", {31'd0, mem_to_reg_out}, 32'd1);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            drive(0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm,
                  tbl[i].rta, tbl[i].rda, tbl[i].p);
            tick();
            chk({tbl[i].name, ".result"},  result_out, tbl[i].res);
            chk({tbl[i].name, ".reg_write"}, {31'd0, reg_write_out}, {31'd0, tbl[i].rw});
            chk({tbl[i].name, ".wr_reg"}, {27'd0, wr_reg_out}, {27'd0, tbl[i].wr});
            chk({tbl[i].name, ".mem_to_reg"}, {31'd0, mem_to_reg_out}, 32'd0);
            chk({tbl[i].name, ".read_data"}, read_data_out, 32'd0);
            chk({tbl[i].name, ".zero"}, {31'd0, zero_out}, {31'd0, tbl[i].z});
            chk({tbl[i].name, ".taken"}, {31'd0, branch_taken}, {31'd0, tbl[i].bt});
            chk({tbl[i].name, ".br_addr"}, branch_addr_out, tbl[i].ba);
            chk({tbl[i].name, ".pc_out"}, pc_out, tbl[i].npc);
        end

        // Store then load of the same word on the next cycle
        drive(0, 6'h2B, 32'h10, 32'hDEADBEEF, 32'd4, 5'd7, 5'd0, 32'h0);
        tick();
        chk("sw.reg_write", {31'd0, reg_write_out}, 32'd0);
        chk("sw.result", result_out, 32'h14);
        chk("sw.read_data", read_data_out, 32'd0);
        drive(0, 6'h23, 32'h10, 32'h0, 32'd4, 5'd3, 5'd0, 32'h0);
        tick();
        chk("lw.read_data", read_data_out, 32'hDEADBEEF);
        chk("lw.mem_to_reg", {31'd0, mem_to_reg_out}, 32'd1);
        chk("lw.wr_reg", {27'd0, wr_reg_out}, 32'd3);
        chk("lw.reg_write", {31'd0, reg_write_out}, 32'd1);

        // Undefined opcode must not write memory (rs+rt = 0x143 -> word 0x50)
        drive(0, 6'h3F, 32'h20, 32'h123, 32'h0, 5'd4, 5'd5, 32'h0);
        tick();
        chk("undef.reg_write", {31'd0, reg_write_out}, 32'd0);
        drive(0, 6'h23, 32'h140, 32'h0, 32'h0, 5'd4, 5'd0, 32'h0);
        tick();
        chk("undef.nowrite", read_data_out, 32'd0);

        // Address 0x400 wraps onto word 0
        drive(0, 6'h2B, 32'h400, 32'hCAFEF00D, 32'h0, 5'd1, 5'd0, 32'h0);
        tick();
        drive(0, 6'h23, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 32'h0);
        tick();
        chk("wrap.read_data", read_data_out, 32'hCAFEF00D);

        // Reset after stores clears memory, and a store during reset is dropped
        drive(1, 6'h2B, 32'h0, 32'h55555555, 32'h0, 5'd1, 5'd0, 32'h0);
        tick(); check_zero("rst_mid");
        drive(0, 6'h23, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 32'h0);
        tick();
        chk("rst_clr.word0", read_data_out, 32'd0);
        drive(0, 6'h23, 32'h10, 32'h0, 32'd4, 5'd1, 5'd0, 32'h0);
        tick();
        chk("rst_clr.word5", read_data_out, 32'd0);

        // Reset mid-stream and recovery on the following cycle
        drive(0, 6'h00, 32'd5, 32'd7, 32'h20, 5'd1, 5'd9, 32'h200);
        tick();
        chk("pre_rst.pc_out", pc_out, 32'h200);
        drive(1, 6'h00, 32'd5, 32'd7, 32'h20, 5'd1, 5'd9, 32'h300);
        tick();
        chk("in_rst.pc_out", pc_out, 32'h0);
        chk("in_rst.result", result_out, 32'h0);
        drive(0, 6'h00, 32'd5, 32'd7, 32'h20, 5'd1, 5'd9, 32'h44);
        tick();
        chk("post_rst.pc_out", pc_out, 32'h44);
        chk("post_rst.result", result_out, 32'd12);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 19);
            ra  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFFF03C);
            rb  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFFF03C);
            rimm = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : 32'($urandom_range(0, 7) * 4);
            case ($urandom_range(0, 5))
                0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
                3: fn = 6'h25; 4: fn = 6'h2A; default: fn = 6'($urandom);
            endcase
            if (sel < 6) begin
                rop = 6'h00; rimm = ($urandom & 32'hFFFFFFC0) | {26'd0, fn};
            end else if (sel < 10) rop = 6'h23;
            else if (sel < 14) rop = 6'h2B;
            else if (sel < 17) begin
                rop = 6'h04;
                if ($urandom_range(0, 1) == 1) rb = ra;
            end else rop = 6'($urandom);
            drive((sel == 19) && ($urandom_range(0, 3) == 0), rop, ra, rb, rimm,
                  5'($urandom), 5'($urandom), $urandom);
            tick();
            check_all($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
